// File: rtl/smi_pkg.sv
// rtl/smi_pkg.sv - shared IOC map, control bits and test-pattern LFSR for the SMI write path
package smi_pkg;

    localparam logic [4:0] IOC_MODULE_VERSION = 5'h00;
    localparam logic [4:0] IOC_STATUS         = 5'h01;
    localparam logic [4:0] IOC_CTRL           = 5'h02;
    localparam logic [4:0] IOC_TEST_ERR       = 5'h03;

    localparam logic [7:0] MODULE_VERSION = 8'h01;
    localparam logic [7:0] LFSR_SEED      = 8'h56;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    // A zero state would lock the LFSR, so it restarts from the seed instead
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        logic [7:0] n;
        n = {s[2] ^ s[3], s[7:1]};
        return (n == 8'h00) ? LFSR_SEED : n;
    endfunction

endpackage

// File: rtl/smi_strobe_sync.sv
// rtl/smi_strobe_sync.sv - synchronizes the SMI write strobe/data and emits one pulse per byte
module smi_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_sys_clk,
    input  logic       i_rst,
    input  logic       i_swe,
    input  logic [7:0] i_data,
    output logic       o_byte_valid,
    output logic [7:0] o_byte
);

    logic [SYNC_STAGES-1:0] swe_pipe;
    logic [7:0]             data_pipe [SYNC_STAGES];
    logic                   swe_d;

    // Data travels through the same depth as the strobe so the byte seen at the edge is the one the RPi held
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            swe_pipe <= '0;
            swe_d    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_pipe[i] <= 8'h00;
            end
        end else begin
            swe_pipe     <= {swe_pipe[SYNC_STAGES-2:0], i_swe};
            swe_d        <= swe_pipe[SYNC_STAGES-1];
            data_pipe[0] <= i_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign o_byte_valid = swe_pipe[SYNC_STAGES-1] & ~swe_d;
    assign o_byte       = data_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/smi_write_deser.sv
// rtl/smi_write_deser.sv - SMI byte-to-word deserializer with IOC registers; SMI_WR_TEST_EN adds LFSR checking
module smi_write_deser
    import smi_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_sys_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_ioc,
    input  logic [7:0]  i_data_in,
    output logic [7:0]  o_data_out,
    input  logic        i_cs,
    input  logic        i_fetch_cmd,
    input  logic        i_load_cmd,
    input  logic        i_smi_swe_srw,
    input  logic [7:0]  i_smi_data_in,
    input  logic        i_smi_test,
    output logic        o_smi_write_req,
    output logic        o_fifo_push,
    output logic [31:0] o_fifo_pushed_data,
    input  logic        i_fifo_full,
    output logic        o_overflow
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             byte_valid;
    logic [7:0]       sync_byte;
    logic [1:0]       byte_idx;
    logic [31:0]      word;
    logic             enable;
    logic             timeout_flag;
    logic [CNT_W-1:0] idle_cnt;
    logic             test_mode;
    logic [7:0]       err_cnt;
    logic [7:0]       rd_data;
    logic             ioc_rd;
    logic             ctrl_wr;
    logic             clear_req;
    logic             accept;

    smi_strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_strobe_sync (
        .i_sys_clk    (i_sys_clk),
        .i_rst        (i_rst),
        .i_swe        (i_smi_swe_srw),
        .i_data       (i_smi_data_in),
        .o_byte_valid (byte_valid),
        .o_byte       (sync_byte)
    );

`ifdef SMI_WR_TEST_EN
    logic [7:0] lfsr;

    assign test_mode = i_smi_test;

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            lfsr    <= LFSR_SEED;
            err_cnt <= 8'h00;
        end else if (clear_req) begin
            lfsr    <= LFSR_SEED;
            err_cnt <= 8'h00;
        end else if (byte_valid && enable && test_mode) begin
            lfsr <= lfsr_next(lfsr);
            if (sync_byte != lfsr && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'h01;
            end
        end
    end
`else
    // The test-select pin stays on the port list but is masked off in this build
    assign test_mode = i_smi_test & 1'b0;
    assign err_cnt   = 8'h00;
`endif

    assign ioc_rd          = i_cs & i_fetch_cmd;
    assign ctrl_wr         = i_cs & i_load_cmd & (i_ioc == IOC_CTRL);
    assign clear_req       = ctrl_wr & i_data_in[CTRL_CLEAR_BIT];
    assign accept          = byte_valid & enable & ~test_mode;
    assign o_smi_write_req = enable & ~i_fifo_full;

    always_comb begin
        rd_data = 8'h00;
        case (i_ioc)
            IOC_MODULE_VERSION: rd_data = MODULE_VERSION;
            IOC_STATUS:         rd_data = {5'b0, timeout_flag, i_fifo_full, o_overflow};
            IOC_CTRL:           rd_data = {6'b0, 1'b0, enable};
            IOC_TEST_ERR:       rd_data = err_cnt;
            default:            rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            o_data_out         <= 8'h00;
            o_fifo_push        <= 1'b0;
            o_fifo_pushed_data <= 32'h0;
            o_overflow         <= 1'b0;
            byte_idx           <= 2'd0;
            word               <= 32'h0;
            enable             <= 1'b1;
            timeout_flag       <= 1'b0;
            idle_cnt           <= '0;
        end else begin
            o_fifo_push <= 1'b0;

            if (ioc_rd) begin
                o_data_out <= rd_data;
            end
            if (ctrl_wr) begin
                enable <= i_data_in[CTRL_ENABLE_BIT];
            end

            if (accept) begin
                idle_cnt <= '0;
                word[31 - 8*byte_idx -: 8] <= sync_byte;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    if (i_fifo_full) begin
                        o_overflow <= 1'b1;
                    end else begin
                        o_fifo_push        <= 1'b1;
                        o_fifo_pushed_data <= {word[31:8], sync_byte};
                    end
                end
            end else if (byte_idx == 2'd0) begin
                idle_cnt <= '0;
            end else if (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                idle_cnt     <= '0;
                byte_idx     <= 2'd0;
                timeout_flag <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            // Issued last so a clear beats an overflow or byte landing in the same cycle
            if (clear_req) begin
                o_overflow   <= 1'b0;
                timeout_flag <= 1'b0;
                byte_idx     <= 2'd0;
                idle_cnt     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_smi_write_deser.sv
// tb/tb_smi_write_deser.sv - directed self-checking bench for smi_write_deser
module tb_smi_write_deser;

    localparam int TMO = 64;

    logic        i_sys_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [4:0]  i_ioc = 5'h0;
    logic [7:0]  i_data_in = 8'h0;
    logic [7:0]  o_data_out;
    logic        i_cs = 1'b0;
    logic        i_fetch_cmd = 1'b0;
    logic        i_load_cmd = 1'b0;
    logic        i_smi_swe_srw = 1'b0;
    logic [7:0]  i_smi_data_in = 8'h0;
    logic        i_smi_test = 1'b0;
    logic        o_smi_write_req;
    logic        o_fifo_push;
    logic [31:0] o_fifo_pushed_data;
    logic        i_fifo_full = 1'b0;
    logic        o_overflow;

    int          checks = 0;
    int          errors = 0;
    int          push_cnt = 0;
    logic [31:0] last_word = 32'h0;
    logic [7:0]  rd;

    smi_write_deser #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_sys_clk          (i_sys_clk),
        .i_rst              (i_rst),
        .i_ioc              (i_ioc),
        .i_data_in          (i_data_in),
        .o_data_out         (o_data_out),
        .i_cs               (i_cs),
        .i_fetch_cmd        (i_fetch_cmd),
        .i_load_cmd         (i_load_cmd),
        .i_smi_swe_srw      (i_smi_swe_srw),
        .i_smi_data_in      (i_smi_data_in),
        .i_smi_test         (i_smi_test),
        .o_smi_write_req    (o_smi_write_req),
        .o_fifo_push        (o_fifo_push),
        .o_fifo_pushed_data (o_fifo_pushed_data),
        .i_fifo_full        (i_fifo_full),
        .o_overflow         (o_overflow)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    always @(negedge i_sys_clk) begin
        if (o_fifo_push) begin
            push_cnt  <= push_cnt + 1;
            last_word <= o_fifo_pushed_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_sys_clk);
        i_smi_data_in = b;
        i_smi_swe_srw = 1'b1;
        repeat (4) @(negedge i_sys_clk);
        i_smi_swe_srw = 1'b0;
        repeat (4) @(negedge i_sys_clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(t[31 - 8*i -: 8]);
        end
        repeat (2) @(negedge i_sys_clk);
    endtask

    task automatic ioc_read(input logic [4:0] a, output logic [7:0] d);
        @(negedge i_sys_clk);
        i_ioc = a; i_cs = 1'b1; i_fetch_cmd = 1'b1;
        @(negedge i_sys_clk);
        i_cs = 1'b0; i_fetch_cmd = 1'b0;
        d = o_data_out;
    endtask

    task automatic ioc_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge i_sys_clk);
        i_ioc = a; i_data_in = d; i_cs = 1'b1; i_load_cmd = 1'b1;
        @(negedge i_sys_clk);
        i_cs = 1'b0; i_load_cmd = 1'b0;
    endtask

    function automatic logic [7:0] model_lfsr(input logic [7:0] s);
        logic [7:0] n;
        n = {s[2] ^ s[3], s[7:1]};
        if (n == 8'h00) n = 8'h56;
        return n;
    endfunction

    initial begin
        int base;
        repeat (3) @(negedge i_sys_clk);
        i_rst = 1'b0;
        @(negedge i_sys_clk);
        check("rst_data_out", {24'h0, o_data_out}, 32'h0);
        check("rst_push", {31'h0, o_fifo_push}, 32'h0);
        check("rst_pushed_data", o_fifo_pushed_data, 32'h0);
        check("rst_overflow", {31'h0, o_overflow}, 32'h0);
        check("rst_write_req", {31'h0, o_smi_write_req}, 32'h1);
        ioc_read(5'h02, rd); check("rst_ctrl", {24'h0, rd}, 32'h01);
        ioc_read(5'h01, rd); check("rst_status", {24'h0, rd}, 32'h00);

        // 1: basic word
        send_word(32'hDEADBEEF);
        check("t1_push_cnt", push_cnt, 1);
        check("t1_word", last_word, 32'hDEADBEEF);
        ioc_read(5'h01, rd); check("t1_status", {24'h0, rd}, 32'h00);
        ioc_read(5'h00, rd); check("t1_version", {24'h0, rd}, 32'h01);
        ioc_read(5'h1F, rd); check("t1_unknown_addr", {24'h0, rd}, 32'h00);

        // 2: overflow and clear
        i_fifo_full = 1'b1;
        @(negedge i_sys_clk);
        check("t2_write_req_full", {31'h0, o_smi_write_req}, 32'h0);
        send_word(32'h01020304);
        check("t2_push_cnt", push_cnt, 1);
        check("t2_overflow", {31'h0, o_overflow}, 32'h1);
        ioc_read(5'h01, rd); check("t2_status", {24'h0, rd}, 32'h03);
        ioc_write(5'h02, 8'h03);
        ioc_read(5'h01, rd); check("t2_status_clr", {24'h0, rd}, 32'h02);
        i_fifo_full = 1'b0;

        // 3: timeout then clean word
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (TMO + 5) @(negedge i_sys_clk);
        ioc_read(5'h01, rd); check("t3_status_tmo", {24'h0, rd}, 32'h04);
        send_word(32'h11223344);
        check("t3_push_cnt", push_cnt, 2);
        check("t3_word", last_word, 32'h11223344);
        ioc_write(5'h02, 8'h03);
        ioc_read(5'h01, rd); check("t3_status_clr", {24'h0, rd}, 32'h00);

        // 4: disable, then re-enable
        ioc_write(5'h02, 8'h00);
        check("t4_write_req_dis", {31'h0, o_smi_write_req}, 32'h0);
        ioc_read(5'h02, rd); check("t4_ctrl_dis", {24'h0, rd}, 32'h00);
        send_word(32'h55667788);
        check("t4_push_cnt_dis", push_cnt, 2);
        ioc_write(5'h02, 8'h01);
        send_word(32'hCAFEBABE);
        check("t4_push_cnt_en", push_cnt, 3);
        check("t4_word", last_word, 32'hCAFEBABE);

        // 5: test mode
        base = push_cnt;
`ifdef SMI_WR_TEST_EN
        begin
            logic [7:0] s;
            s = 8'h56;
            i_smi_test = 1'b1;
            for (int i = 0; i < 10; i++) begin
                send_byte(s);
                s = model_lfsr(s);
            end
            ioc_read(5'h03, rd); check("t5_err_zero", {24'h0, rd}, 32'h00);
            send_byte(~s);
            ioc_read(5'h03, rd); check("t5_err_one", {24'h0, rd}, 32'h01);
            check("t5_no_push", push_cnt, base);
            ioc_write(5'h02, 8'h03);
            ioc_read(5'h03, rd); check("t5_err_clr", {24'h0, rd}, 32'h00);
            i_smi_test = 1'b0;
        end
`else
        i_smi_test = 1'b1;
        ioc_read(5'h03, rd); check("t5_test_reg", {24'h0, rd}, 32'h00);
        send_word(32'h0A0B0C0D);
        check("t5_push_cnt", push_cnt, base + 1);
        check("t5_word", last_word, 32'h0A0B0C0D);
        i_smi_test = 1'b0;
        check("t5_lfsr_model", {24'h0, model_lfsr(8'h56)}, 32'hAB);
`endif

        // 6: reset mid-word
        i_fifo_full = 1'b1;
        send_word(32'hFFEEDDCC);
        i_fifo_full = 1'b0;
        ioc_read(5'h01, rd); check("t6_status_pre", {24'h0, rd}, 32'h01);
        send_byte(8'h99);
        send_byte(8'h88);
        send_byte(8'h77);
        @(negedge i_sys_clk);
        i_rst = 1'b1;
        repeat (2) @(negedge i_sys_clk);
        i_rst = 1'b0;
        check("t6_data_out", {24'h0, o_data_out}, 32'h0);
        check("t6_overflow", {31'h0, o_overflow}, 32'h0);
        check("t6_pushed_data", o_fifo_pushed_data, 32'h0);
        check("t6_push", {31'h0, o_fifo_push}, 32'h0);
        base = push_cnt;
        send_word(32'h12345678);
        check("t6_push_cnt", push_cnt, base + 1);
        check("t6_word", last_word, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
